mem_stage: RTL and testbench

Memory stage of the five-stage RISC-V pipeline. It takes the load/store request and the result registered by the execute stage, runs one transaction on the data-memory bus, aligns and extends load data, and raises memory exceptions. It registers the result into the writeback stage and back-pressures execute through `ready_mem`.

---
 rtl/riscv_pkg.sv | 44 ++++
 rtl/lsu_align.sv | 48 ++++
 rtl/mem_stage.sv | 202 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: LSU request encodings, register-tag width,
// memory-stage FSM states and memory exception causes.
package riscv_pkg;

    localparam int TAG_WIDTH = 3;

    typedef enum logic {
        LSU_LOAD  = 1'b0,
        LSU_STORE = 1'b1
    } lsu_op_e;

    typedef enum logic [2:0] {
        LSU_B  = 3'd0,
        LSU_H  = 3'd1,
        LSU_W  = 3'd2,
        LSU_BU = 3'd4,
        LSU_HU = 3'd5
    } lsu_dtype_e;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2,
        DONE        = 2'd3
    } mem_state_e;

    localparam logic [5:0] EXC_LD_MISALIGN = 6'd4;
    localparam logic [5:0] EXC_LD_FAULT    = 6'd5;
    localparam logic [5:0] EXC_ST_MISALIGN = 6'd6;
    localparam logic [5:0] EXC_ST_FAULT    = 6'd7;

    // Halves must sit on an even address, words on a multiple of four.
    function automatic logic is_misaligned(lsu_dtype_e dtype, logic [1:0] offset);
        logic result;
        result = 1'b0;
        case (dtype)
            LSU_H, LSU_HU: result = offset[0];
            LSU_W:         result = |offset;
            default:       result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the data bus: store byte enables and replicated store
// data, plus right-shift and sign/zero extension of load data.
module lsu_align
    import riscv_pkg::*;
(
    input  lsu_dtype_e  dtype,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext
);

    logic        byte_sel;
    logic        half_sel;
    logic [31:0] shifted;

    assign byte_sel = (dtype == LSU_B) || (dtype == LSU_BU);
    assign half_sel = (dtype == LSU_H) || (dtype == LSU_HU);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign be[gi] = byte_sel ? (offset == 2'(gi)) :
                            half_sel ? (offset[1] == 1'(gi / 2)) :
                                       1'b1;
            // Each lane carries the low byte/half so any lane the enables pick is correct.
            assign wdata_lanes[8*gi +: 8] = byte_sel ? wdata[7:0] :
                                            half_sel ? wdata[8*(gi%2) +: 8] :
                                                       wdata[8*gi +: 8];
        end
    endgenerate

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        rdata_ext = shifted;
        case (dtype)
            LSU_B:   rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            LSU_BU:  rdata_ext = {24'b0, shifted[7:0]};
            LSU_H:   rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            LSU_HU:  rdata_ext = {16'b0, shifted[15:0]};
            default: rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the five-stage RISC-V pipeline: one outstanding data-bus access,
// load alignment, memory exceptions. Optional macro MEM_MISALIGN_CHECK_EN traps misaligned accesses.
module mem_stage
    import riscv_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall_M,
    input  logic                 ready_wb,
    output logic                 ready_mem,

    input  logic                 lsu_en_mem,
    input  lsu_op_e              lsu_op_mem,
    input  lsu_dtype_e           lsu_dtype_mem,
    input  logic [31:0]          lsu_addr_mem,
    input  logic [31:0]          lsu_wdata_mem,

    input  logic                 rd_wr_en_mem,
    input  logic [TAG_WIDTH-1:0] rd_wr_tag_mem,
    input  logic [4:0]           rd_wr_addr_mem,
    input  logic [31:0]          rd_wr_data_mem,

    input  logic                 exc_taken_mem,
    input  logic [5:0]           exc_cause_mem,
    input  logic [31:0]          exc_tval_mem,

    output logic                 data_req,
    output logic                 data_we,
    output logic [3:0]           data_be,
    output logic [31:0]          data_addr,
    output logic [31:0]          data_wdata,
    input  logic                 data_gnt,
    input  logic                 data_rvalid,
    input  logic [31:0]          data_rdata,
    input  logic                 data_err,

    output logic                 rd_wr_en_wb,
    output logic [TAG_WIDTH-1:0] rd_wr_tag_wb,
    output logic [4:0]           rd_wr_addr_wb,
    output logic [31:0]          rd_wr_data_wb,

    output logic                 exc_taken_wb,
    output logic [5:0]           exc_cause_wb,
    output logic [31:0]          exc_tval_wb,

    output logic                 forward_mem_en,
    output logic [TAG_WIDTH-1:0] forward_mem_tag,
    output logic [4:0]           forward_mem_addr,
    output logic [31:0]          forward_mem_wdata
);

    mem_state_e  state_reg, state_next;
    logic [31:0] hold_rdata_reg;
    logic        hold_err_reg;

    logic        is_load;
    logic        misaligned;
    logic        need;
    logic        access;
    logic        done;
    logic        advance;
    logic        req_comb;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;
    logic [31:0] result_data;
    logic        exc_taken_next;
    logic [5:0]  exc_cause_next;
    logic [31:0] exc_tval_next;

    assign is_load = (lsu_op_mem == LSU_LOAD);

`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned = lsu_en_mem & is_misaligned(lsu_dtype_mem, lsu_addr_mem[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign need    = lsu_en_mem & ~exc_taken_mem & ~misaligned;
    assign access  = need & ~stall_M;
    assign done    = ~need
                   | ((state_reg == WAIT_RVALID) & data_rvalid)
                   | (state_reg == DONE);
    assign advance = ~stall_M & ready_wb & done;
    assign ready_mem = advance;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        req_comb   = 1'b0;
        case (state_reg)
            IDLE: begin
                req_comb = access;
                if (access) begin
                    state_next = data_gnt ? WAIT_RVALID : WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                req_comb = 1'b1;
                if (data_gnt) begin
                    state_next = WAIT_RVALID;
                end
            end
            WAIT_RVALID: begin
                if (data_rvalid) begin
                    state_next = advance ? IDLE : DONE;
                end
            end
            DONE: begin
                if (advance) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Keep the bus quiet while reset is held even if execute still presents a request.
    assign data_req   = req_comb & reset_n;
    assign data_we    = data_req & ~is_load;
    assign data_be    = data_req ? lane_be : 4'b0;
    assign data_addr  = data_req ? {lsu_addr_mem[31:2], 2'b00} : 32'b0;
    assign data_wdata = (data_req & ~is_load) ? lane_wdata : 32'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_rdata_reg <= 32'b0;
            hold_err_reg   <= 1'b0;
        end else if ((state_reg == WAIT_RVALID) && data_rvalid) begin
            hold_rdata_reg <= data_rdata;
            hold_err_reg   <= data_err;
        end
    end

    // Live response in the rvalid cycle, captured copy while waiting in DONE.
    assign resp_rdata = (state_reg == DONE) ? hold_rdata_reg : data_rdata;
    assign resp_err   = (state_reg == DONE) ? hold_err_reg   : (data_err & data_rvalid);

    lsu_align u_align (
        .dtype       (lsu_dtype_mem),
        .offset      (lsu_addr_mem[1:0]),
        .wdata       (lsu_wdata_mem),
        .rdata       (resp_rdata),
        .be          (lane_be),
        .wdata_lanes (lane_wdata),
        .rdata_ext   (load_data)
    );

    assign result_data = (lsu_en_mem & is_load) ? load_data : rd_wr_data_mem;

    always_comb begin
        exc_taken_next = exc_taken_mem;
        exc_cause_next = exc_cause_mem;
        exc_tval_next  = exc_tval_mem;
        if (!exc_taken_mem) begin
            if (misaligned) begin
                exc_taken_next = 1'b1;
                exc_cause_next = is_load ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
                exc_tval_next  = lsu_addr_mem;
            end else if (need && resp_err) begin
                exc_taken_next = 1'b1;
                exc_cause_next = is_load ? EXC_LD_FAULT : EXC_ST_FAULT;
                exc_tval_next  = lsu_addr_mem;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_wr_en_wb   <= 1'b0;
            rd_wr_tag_wb  <= '0;
            rd_wr_addr_wb <= 5'b0;
            rd_wr_data_wb <= 32'b0;
            exc_taken_wb  <= 1'b0;
            exc_cause_wb  <= 6'b0;
            exc_tval_wb   <= 32'b0;
        end else if (advance) begin
            rd_wr_en_wb   <= rd_wr_en_mem & ~exc_taken_next;
            rd_wr_tag_wb  <= rd_wr_tag_mem;
            rd_wr_addr_wb <= rd_wr_addr_mem;
            rd_wr_data_wb <= result_data;
            exc_taken_wb  <= exc_taken_next;
            exc_cause_wb  <= exc_cause_next;
            exc_tval_wb   <= exc_tval_next;
        end
    end

    assign forward_mem_en    = rd_wr_en_mem & ~exc_taken_mem & (~lsu_en_mem | (is_load & done));
    assign forward_mem_tag   = rd_wr_tag_mem;
    assign forward_mem_addr  = rd_wr_addr_mem;
    assign forward_mem_wdata = result_data;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed bus scenarios plus a randomized mix
// checked against an arithmetic model of lane selection and load extension.
module tb_mem_stage;
    import riscv_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 stall_M, ready_wb, ready_mem;
    logic                 lsu_en_mem;
    lsu_op_e              lsu_op_mem;
    lsu_dtype_e           lsu_dtype_mem;
    logic [31:0]          lsu_addr_mem, lsu_wdata_mem;
    logic                 rd_wr_en_mem;
    logic [TAG_WIDTH-1:0] rd_wr_tag_mem;
    logic [4:0]           rd_wr_addr_mem;
    logic [31:0]          rd_wr_data_mem;
    logic                 exc_taken_mem;
    logic [5:0]           exc_cause_mem;
    logic [31:0]          exc_tval_mem;
    logic                 data_req, data_we, data_gnt, data_rvalid, data_err;
    logic [3:0]           data_be;
    logic [31:0]          data_addr, data_wdata, data_rdata;
    logic                 rd_wr_en_wb;
    logic [TAG_WIDTH-1:0] rd_wr_tag_wb;
    logic [4:0]           rd_wr_addr_wb;
    logic [31:0]          rd_wr_data_wb;
    logic                 exc_taken_wb;
    logic [5:0]           exc_cause_wb;
    logic [31:0]          exc_tval_wb;
    logic                 forward_mem_en;
    logic [TAG_WIDTH-1:0] forward_mem_tag;
    logic [4:0]           forward_mem_addr;
    logic [31:0]          forward_mem_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset_n(reset_n), .stall_M(stall_M), .ready_wb(ready_wb), .ready_mem(ready_mem),
        .lsu_en_mem(lsu_en_mem), .lsu_op_mem(lsu_op_mem), .lsu_dtype_mem(lsu_dtype_mem),
        .lsu_addr_mem(lsu_addr_mem), .lsu_wdata_mem(lsu_wdata_mem),
        .rd_wr_en_mem(rd_wr_en_mem), .rd_wr_tag_mem(rd_wr_tag_mem),
        .rd_wr_addr_mem(rd_wr_addr_mem), .rd_wr_data_mem(rd_wr_data_mem),
        .exc_taken_mem(exc_taken_mem), .exc_cause_mem(exc_cause_mem), .exc_tval_mem(exc_tval_mem),
        .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata), .data_err(data_err),
        .rd_wr_en_wb(rd_wr_en_wb), .rd_wr_tag_wb(rd_wr_tag_wb), .rd_wr_addr_wb(rd_wr_addr_wb),
        .rd_wr_data_wb(rd_wr_data_wb), .exc_taken_wb(exc_taken_wb), .exc_cause_wb(exc_cause_wb),
        .exc_tval_wb(exc_tval_wb), .forward_mem_en(forward_mem_en), .forward_mem_tag(forward_mem_tag),
        .forward_mem_addr(forward_mem_addr), .forward_mem_wdata(forward_mem_wdata)
    );

    // ---------------- reference model ----------------
    function automatic int m_size(lsu_dtype_e dt);
        if (dt == LSU_W) return 4;
        if (dt == LSU_H || dt == LSU_HU) return 2;
        return 1;
    endfunction

    function automatic logic [3:0] m_be(lsu_dtype_e dt, logic [31:0] a);
        int sz = m_size(dt);
        int first = (int'(a % 4) / sz) * sz;
        logic [3:0] r = 4'b0;
        for (int i = 0; i < sz; i++) r[first + i] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] m_wdata(lsu_dtype_e dt, logic [31:0] wd);
        int sz = m_size(dt);
        longint v = longint'(wd) % (longint'(1) << (8 * sz));
        longint r = 0;
        for (int i = 0; i < 4 / sz; i++) r = r + (v << (8 * sz * i));
        return 32'(r);
    endfunction

    function automatic logic [31:0] m_load(lsu_dtype_e dt, logic [31:0] a, logic [31:0] rd);
        int sz = m_size(dt);
        longint full = longint'(1) << (8 * sz);
        longint v = (longint'(rd) >> (8 * int'(a % 4))) % full;
        if ((dt == LSU_B || dt == LSU_H) && v >= full / 2) v = v - full;
        return 32'(v);
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        stall_M = 1'b0; ready_wb = 1'b1;
        lsu_en_mem = 1'b0; lsu_op_mem = LSU_LOAD; lsu_dtype_mem = LSU_W;
        lsu_addr_mem = 32'h0; lsu_wdata_mem = 32'h0;
        rd_wr_en_mem = 1'b0; rd_wr_tag_mem = '0; rd_wr_addr_mem = 5'd0; rd_wr_data_mem = 32'h0;
        exc_taken_mem = 1'b0; exc_cause_mem = 6'd0; exc_tval_mem = 32'h0;
        data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = 32'h0; data_err = 1'b0;
    endtask

    task automatic set_mem(lsu_op_e op, lsu_dtype_e dt, logic [31:0] a, logic [31:0] wd, logic [4:0] rd);
        lsu_en_mem = 1'b1; lsu_op_mem = op; lsu_dtype_mem = dt;
        lsu_addr_mem = a; lsu_wdata_mem = wd;
        rd_wr_en_mem = (op == LSU_LOAD) && (rd != 5'd0);
        rd_wr_addr_mem = rd; rd_wr_tag_mem = TAG_WIDTH'(rd);
        rd_wr_data_mem = $urandom;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive_idle();
        reset_n = 1'b0;
        set_mem(LSU_LOAD, LSU_W, 32'h40, 32'h0, 5'd1);
        data_gnt = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", data_req); end
        checks++; if ({data_we, data_be, data_addr, data_wdata} !== 69'b0) begin errors++;
            $display("FAIL reset_bus got %h exp 0", {data_we, data_be, data_addr, data_wdata}); end
        checks++; if ({rd_wr_en_wb, rd_wr_tag_wb, rd_wr_addr_wb, rd_wr_data_wb} !== '0) begin errors++;
            $display("FAIL reset_rd_wb got %h exp 0", {rd_wr_en_wb, rd_wr_tag_wb, rd_wr_addr_wb, rd_wr_data_wb}); end
        checks++; if ({exc_taken_wb, exc_cause_wb, exc_tval_wb} !== 39'b0) begin errors++;
            $display("FAIL reset_exc_wb got %h exp 0", {exc_taken_wb, exc_cause_wb, exc_tval_wb}); end
        drive_idle();
        tick();
        reset_n = 1'b1;
        tick();
        $display("txn reset done");
    endtask

    task automatic test_load_byte();
        set_mem(LSU_LOAD, LSU_B, 32'h1003, 32'h0, 5'd7);
        data_gnt = 1'b1;
        @(negedge clk);
        checks++; if ({data_req, data_we, data_be, data_addr} !== {1'b1, 1'b0, 4'b1000, 32'h1000}) begin errors++;
            $display("FAIL lb_bus got %h exp %h", {data_req, data_we, data_be, data_addr}, {1'b1, 1'b0, 4'b1000, 32'h1000}); end
        checks++; if (ready_mem !== 1'b0) begin errors++; $display("FAIL lb_ready_n got %b exp 0", ready_mem); end
        tick();
        data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = 32'h80FF_FF12;
        @(negedge clk);
        checks++; if (ready_mem !== 1'b1) begin errors++; $display("FAIL lb_ready_n1 got %b exp 1", ready_mem); end
        checks++; if ({forward_mem_en, forward_mem_wdata} !== {1'b1, 32'hFFFF_FF80}) begin errors++;
            $display("FAIL lb_fwd got %h exp %h", {forward_mem_en, forward_mem_wdata}, {1'b1, 32'hFFFF_FF80}); end
        tick();
        drive_idle();
        checks++; if ({rd_wr_en_wb, rd_wr_addr_wb, rd_wr_data_wb, exc_taken_wb} !== {1'b1, 5'd7, 32'hFFFF_FF80, 1'b0}) begin errors++;
            $display("FAIL lb_wb got %h exp %h", {rd_wr_en_wb, rd_wr_addr_wb, rd_wr_data_wb, exc_taken_wb}, {1'b1, 5'd7, 32'hFFFF_FF80, 1'b0}); end
        $display("txn LB 0x1003 -> wb %h", rd_wr_data_wb);
    endtask

    task automatic test_store_delayed_gnt();
        set_mem(LSU_STORE, LSU_H, 32'h2002, 32'h0000_ABCD, 5'd0);
        for (int c = 0; c <= 3; c++) begin
            data_gnt = (c == 3);
            @(negedge clk);
            checks++; if ({data_req, data_we, data_be, data_addr, data_wdata} !== {1'b1, 1'b1, 4'b1100, 32'h2000, 32'hABCD_ABCD}) begin errors++;
                $display("FAIL sh_bus_c%0d got %h exp %h", c, {data_req, data_we, data_be, data_addr, data_wdata}, {1'b1, 1'b1, 4'b1100, 32'h2000, 32'hABCD_ABCD}); end
            checks++; if (ready_mem !== 1'b0) begin errors++; $display("FAIL sh_ready_c%0d got %b exp 0", c, ready_mem); end
            tick();
        end
        data_gnt = 1'b0;
        @(negedge clk);
        checks++; if ({data_req, ready_mem} !== 2'b00) begin errors++; $display("FAIL sh_wait got %b exp 00", {data_req, ready_mem}); end
        tick();
        data_rvalid = 1'b1; data_rdata = $urandom;
        @(negedge clk);
        checks++; if (ready_mem !== 1'b1) begin errors++; $display("FAIL sh_ready_rv got %b exp 1", ready_mem); end
        tick();
        drive_idle();
        checks++; if ({rd_wr_en_wb, exc_taken_wb} !== 2'b00) begin errors++; $display("FAIL sh_wb got %b exp 00", {rd_wr_en_wb, exc_taken_wb}); end
        $display("txn SH 0x2002 gnt after 3");
    endtask

    task automatic test_backpressure();
        logic [31:0] r = $urandom;
        set_mem(LSU_LOAD, LSU_W, 32'h0000_0030, 32'h0, 5'd9);
        data_gnt = 1'b1;
        tick();
        data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = r; ready_wb = 1'b0;
        @(negedge clk);
        checks++; if (ready_mem !== 1'b0) begin errors++; $display("FAIL bp_ready_rv got %b exp 0", ready_mem); end
        tick();
        data_rvalid = 1'b0; data_rdata = ~r; data_err = 1'b1;
        @(negedge clk);
        checks++; if ({data_req, ready_mem} !== 2'b00) begin errors++; $display("FAIL bp_done got %b exp 00", {data_req, ready_mem}); end
        tick();
        ready_wb = 1'b1;
        @(negedge clk);
        checks++; if ({ready_mem, data_req, forward_mem_wdata} !== {1'b1, 1'b0, r}) begin errors++;
            $display("FAIL bp_release got %h exp %h", {ready_mem, data_req, forward_mem_wdata}, {1'b1, 1'b0, r}); end
        tick();
        drive_idle();
        checks++; if ({rd_wr_en_wb, rd_wr_data_wb, exc_taken_wb} !== {1'b1, r, 1'b0}) begin errors++;
            $display("FAIL bp_wb got %h exp %h", {rd_wr_en_wb, rd_wr_data_wb, exc_taken_wb}, {1'b1, r, 1'b0}); end
        $display("txn LW backpressure wb %h", rd_wr_data_wb);
    endtask

    task automatic test_bus_error();
        set_mem(LSU_LOAD, LSU_W, 32'h0000_0044, 32'h0, 5'd3);
        data_gnt = 1'b1;
        tick();
        data_gnt = 1'b0; data_rvalid = 1'b1; data_err = 1'b1; data_rdata = $urandom;
        @(negedge clk);
        checks++; if (ready_mem !== 1'b1) begin errors++; $display("FAIL err_ready got %b exp 1", ready_mem); end
        tick();
        drive_idle();
        checks++; if ({exc_taken_wb, exc_cause_wb, exc_tval_wb, rd_wr_en_wb} !== {1'b1, EXC_LD_FAULT, 32'h44, 1'b0}) begin errors++;
            $display("FAIL err_wb got %h exp %h", {exc_taken_wb, exc_cause_wb, exc_tval_wb, rd_wr_en_wb}, {1'b1, EXC_LD_FAULT, 32'h44, 1'b0}); end
        $display("txn LW bus error cause %0d", exc_cause_wb);
    endtask

    task automatic test_misalign();
        logic [31:0] r = $urandom;
        set_mem(LSU_LOAD, LSU_W, 32'h0000_0002, 32'h0, 5'd4);
`ifdef MEM_MISALIGN_CHECK_EN
        @(negedge clk);
        checks++; if ({data_req, ready_mem} !== 2'b01) begin errors++; $display("FAIL mis_req got %b exp 01", {data_req, ready_mem}); end
        tick();
        drive_idle();
        checks++; if ({exc_taken_wb, exc_cause_wb, exc_tval_wb, rd_wr_en_wb} !== {1'b1, EXC_LD_MISALIGN, 32'h2, 1'b0}) begin errors++;
            $display("FAIL mis_wb got %h exp %h", {exc_taken_wb, exc_cause_wb, exc_tval_wb, rd_wr_en_wb}, {1'b1, EXC_LD_MISALIGN, 32'h2, 1'b0}); end
`else
        data_gnt = 1'b1;
        @(negedge clk);
        checks++; if ({data_req, data_be, data_addr} !== {1'b1, 4'b1111, 32'h0}) begin errors++;
            $display("FAIL mis_bus got %h exp %h", {data_req, data_be, data_addr}, {1'b1, 4'b1111, 32'h0}); end
        tick();
        data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = r;
        @(negedge clk);
        checks++; if (ready_mem !== 1'b1) begin errors++; $display("FAIL mis_ready got %b exp 1", ready_mem); end
        tick();
        drive_idle();
        checks++; if ({rd_wr_en_wb, rd_wr_data_wb, exc_taken_wb} !== {1'b1, m_load(LSU_W, 32'h2, r), 1'b0}) begin errors++;
            $display("FAIL mis_wb got %h exp %h", {rd_wr_en_wb, rd_wr_data_wb, exc_taken_wb}, {1'b1, m_load(LSU_W, 32'h2, r), 1'b0}); end
`endif
        $display("txn LW 0x0002 exc=%b", exc_taken_wb);
    endtask

    task automatic test_reset_mid();
        logic [31:0] r = $urandom;
        set_mem(LSU_LOAD, LSU_W, 32'h0000_0050, 32'h0, 5'd5);
        data_gnt = 1'b1;
        tick();
        data_gnt = 1'b0;
        reset_n = 1'b0;
        drive_idle();
        #1;
        checks++; if ({rd_wr_en_wb, rd_wr_data_wb, exc_taken_wb, data_req} !== 35'b0) begin errors++;
            $display("FAIL rstmid_out got %h exp 0", {rd_wr_en_wb, rd_wr_data_wb, exc_taken_wb, data_req}); end
        tick();
        reset_n = 1'b1;
        // A stale rvalid arriving together with a fresh request must not complete it.
        set_mem(LSU_LOAD, LSU_W, 32'h0000_0060, 32'h0, 5'd6);
        data_rvalid = 1'b1; data_rdata = ~r;
        @(negedge clk);
        checks++; if ({data_req, ready_mem} !== 2'b10) begin errors++; $display("FAIL rstmid_late got %b exp 10", {data_req, ready_mem}); end
        tick();
        data_rvalid = 1'b0; data_gnt = 1'b1;
        tick();
        data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = r;
        @(negedge clk);
        checks++; if (ready_mem !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", ready_mem); end
        tick();
        drive_idle();
        checks++; if ({rd_wr_en_wb, rd_wr_addr_wb, rd_wr_data_wb} !== {1'b1, 5'd6, r}) begin errors++;
            $display("FAIL rstmid_wb got %h exp %h", {rd_wr_en_wb, rd_wr_addr_wb, rd_wr_data_wb}, {1'b1, 5'd6, r}); end
        $display("txn reset mid-transaction, next LW wb %h", rd_wr_data_wb);
    endtask

    task automatic test_random();
        lsu_op_e op; lsu_dtype_e dt;
        logic [31:0] a, wd, rdv, rdm, exp_ld, exp_data;
        logic [4:0] rd; logic err; int kind, sz, gd, rv, ws;
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                rd = 5'($urandom_range(1, 31));
                rd_wr_en_mem = 1'b1; rd_wr_addr_mem = rd; rd_wr_tag_mem = TAG_WIDTH'(rd); rd_wr_data_mem = $urandom;
                @(negedge clk);
                checks++; if ({ready_mem, data_req, forward_mem_en, forward_mem_addr, forward_mem_wdata} !== {1'b1, 1'b0, 1'b1, rd, rd_wr_data_mem}) begin errors++;
                    $display("FAIL rnd_alu_comb t%0d got %h exp %h", t, {ready_mem, data_req, forward_mem_en, forward_mem_addr, forward_mem_wdata}, {1'b1, 1'b0, 1'b1, rd, rd_wr_data_mem}); end
                exp_data = rd_wr_data_mem;
                tick();
                checks++; if ({rd_wr_en_wb, rd_wr_addr_wb, rd_wr_tag_wb, rd_wr_data_wb, exc_taken_wb} !== {1'b1, rd, TAG_WIDTH'(rd), exp_data, 1'b0}) begin errors++;
                    $display("FAIL rnd_alu_wb t%0d got %h exp %h", t, {rd_wr_en_wb, rd_wr_addr_wb, rd_wr_tag_wb, rd_wr_data_wb, exc_taken_wb}, {1'b1, rd, TAG_WIDTH'(rd), exp_data, 1'b0}); end
            end else if (kind == 1) begin
                set_mem(LSU_STORE, LSU_W, $urandom & 32'hFFFF_FFFC, $urandom, 5'd0);
                lsu_en_mem = 1'($urandom_range(0, 1)); rd_wr_en_mem = 1'b1;
                exc_taken_mem = 1'b1; exc_cause_mem = 6'($urandom_range(0, 15)); exc_tval_mem = $urandom;
                @(negedge clk);
                checks++; if ({ready_mem, data_req, forward_mem_en} !== 3'b100) begin errors++;
                    $display("FAIL rnd_exc_comb t%0d got %b exp 100", t, {ready_mem, data_req, forward_mem_en}); end
                tick();
                checks++; if ({exc_taken_wb, exc_cause_wb, exc_tval_wb, rd_wr_en_wb} !== {1'b1, exc_cause_mem, exc_tval_mem, 1'b0}) begin errors++;
                    $display("FAIL rnd_exc_wb t%0d got %h exp %h", t, {exc_taken_wb, exc_cause_wb, exc_tval_wb, rd_wr_en_wb}, {1'b1, exc_cause_mem, exc_tval_mem, 1'b0}); end
            end else begin
                op = $urandom_range(0, 1) ? LSU_STORE : LSU_LOAD;
                case ($urandom_range(0, 4))
                    0: dt = LSU_B; 1: dt = LSU_BU; 2: dt = LSU_H; 3: dt = LSU_HU; default: dt = LSU_W;
                endcase
                sz = m_size(dt);
                a = ($urandom & 32'hFFFF_FFFC) + 32'(($urandom_range(0, 3) / sz) * sz);
                wd = $urandom; rdv = $urandom; err = ($urandom_range(0, 7) == 0);
                rd = (op == LSU_LOAD) ? 5'($urandom_range(0, 31)) : 5'd0;
                set_mem(op, dt, a, wd, rd);
                rdm = rd_wr_data_mem;
                exp_ld = m_load(dt, a, rdv);
                if ($urandom_range(0, 3) == 0) begin
                    stall_M = 1'b1;
                    @(negedge clk);
                    checks++; if ({data_req, ready_mem} !== 2'b00) begin errors++; $display("FAIL rnd_stall t%0d got %b exp 00", t, {data_req, ready_mem}); end
                    tick();
                    stall_M = 1'b0;
                end
                gd = $urandom_range(0, 3); rv = $urandom_range(0, 2); ws = $urandom_range(0, 2);
                for (int c = 0; c <= gd; c++) begin
                    data_gnt = (c == gd);
                    @(negedge clk);
                    checks++; if ({data_req, ready_mem, data_we, data_be, data_addr} !== {1'b1, 1'b0, op == LSU_STORE, m_be(dt, a), a & 32'hFFFF_FFFC}) begin errors++;
                        $display("FAIL rnd_req t%0d got %h exp %h", t, {data_req, ready_mem, data_we, data_be, data_addr}, {1'b1, 1'b0, op == LSU_STORE, m_be(dt, a), a & 32'hFFFF_FFFC}); end
                    if (op == LSU_STORE) begin
                        checks++; if (data_wdata !== m_wdata(dt, wd)) begin errors++; $display("FAIL rnd_wdata t%0d got %h exp %h", t, data_wdata, m_wdata(dt, wd)); end
                    end
                    tick();
                end
                data_gnt = 1'b0;
                for (int c = 0; c < rv; c++) begin
                    @(negedge clk);
                    checks++; if ({data_req, ready_mem} !== 2'b00) begin errors++; $display("FAIL rnd_wait t%0d got %b exp 00", t, {data_req, ready_mem}); end
                    tick();
                end
                data_rvalid = 1'b1; data_rdata = rdv; data_err = err; ready_wb = (ws == 0);
                @(negedge clk);
                checks++; if ({ready_mem, forward_mem_en} !== {ws == 0, rd != 5'd0}) begin errors++;
                    $display("FAIL rnd_rv t%0d got %b exp %b", t, {ready_mem, forward_mem_en}, {ws == 0, rd != 5'd0}); end
                tick();
                data_rvalid = 1'b0; data_rdata = $urandom; data_err = 1'($urandom_range(0, 1));
                for (int k = 1; k <= ws; k++) begin
                    ready_wb = (k == ws);
                    @(negedge clk);
                    checks++; if ({ready_mem, data_req} !== {k == ws, 1'b0}) begin errors++;
                        $display("FAIL rnd_hold t%0d got %b exp %b", t, {ready_mem, data_req}, {k == ws, 1'b0}); end
                    tick();
                end
                exp_data = (op == LSU_LOAD) ? exp_ld : rdm;
                checks++; if ({rd_wr_en_wb, rd_wr_data_wb, exc_taken_wb} !== {(rd != 5'd0) && !err, exp_data, err}) begin errors++;
                    $display("FAIL rnd_wb t%0d got %h exp %h", t, {rd_wr_en_wb, rd_wr_data_wb, exc_taken_wb}, {(rd != 5'd0) && !err, exp_data, err}); end
                if (err) begin
                    checks++; if ({exc_cause_wb, exc_tval_wb} !== {(op == LSU_LOAD) ? EXC_LD_FAULT : EXC_ST_FAULT, a}) begin errors++;
                        $display("FAIL rnd_fault t%0d got %h exp %h", t, {exc_cause_wb, exc_tval_wb}, {(op == LSU_LOAD) ? EXC_LD_FAULT : EXC_ST_FAULT, a}); end
                end
            end
            $display("txn %0d kind=%0d wb_en=%b wb_data=%h exc=%b", t, kind, rd_wr_en_wb, rd_wr_data_wb, exc_taken_wb);
            drive_idle();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_byte();
        test_store_delayed_gnt();
        test_backpressure();
        test_bus_error();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
